// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized rx, start/data/stop framing, one-entry valid/ready output buffer.
// Optional even-parity bit is enabled by defining UART_PARITY_EN.
module uart_rx #(
  parameter int BAUD_DIV  = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  // Handshake: a word transfers on any clock edge where rx_valid & rx_ready are both high;
  // rx_data is held stable from rx_valid rising until that transfer.

  localparam int CW = $clog2(BAUD_DIV);
  localparam int BW = $clog2(DATA_BITS + 1);

  // The IDLE cycle that detects the falling edge counts as the first half-bit cycle.
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 2);
  localparam logic [CW-1:0] FULL_LAST = CW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t               state;
  logic                 rx_meta;
  logic                 rx_s;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 frame_done;
`ifdef UART_PARITY_EN
  logic                 par_bad;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      frame_done <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      frame_done <= 1'b0;
`ifdef UART_PARITY_EN
      parity_err <= 1'b0;
`endif

      // Output buffer: a completing frame may load in the same cycle the old word is taken.
      if (frame_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
`ifdef UART_PARITY_EN
          parity_err <= par_bad;
`endif
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == FULL_LAST) begin
            cnt   <= '0;
            shift <= {rx_s, shift[DATA_BITS-1:1]};
            if (bit_cnt == BITS_LAST) begin
              bit_cnt <= '0;
`ifdef UART_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (cnt == FULL_LAST) begin
            cnt     <= '0;
            par_bad <= (^shift) ^ rx_s;
            state   <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          if (cnt == FULL_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              frame_done <= 1'b1;
              state      <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef UART_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial UART receiver for the slave end of the uart_bus link. It recovers frames from the `rx` line: 1 start bit (low), DATA_BITS data bits LSB first, an optional parity bit, and 1 stop bit (high). Each received word is presented through a one-entry output buffer with a valid/ready handshake. Frame, overrun and parity errors are reported as single-cycle pulses.

Parameters:
BAUD_DIV, 16, clk cycles per bit period; even, >= 4
DATA_BITS, 8, data bits per frame; 5..9

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx  input  1  serial line, idle high, asynchronous to clk
rx_data  output  DATA_BITS  received word, stable while rx_valid=1
rx_valid  output  1  rx_data holds an unconsumed word
rx_ready  input  1  consumer accepts word when rx_valid & rx_ready
frame_err  output  1  1-cycle pulse: stop bit sampled low
overrun  output  1  1-cycle pulse: frame completed while buffer full
parity_err  output  1  1-cycle pulse: parity mismatch (tied 0 without macro)

Behaviour:
- One clock (`clk`). Reset `rst_n` is asynchronous, active-low, and applied immediately.
- Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, parity_err=0; FSM=IDLE; counters=0; synchronizer flops=1.
- Reset asserted mid-frame aborts the frame; nothing is delivered.
- `rx` passes through a 2-flop synchronizer (rx_s); all decisions use rx_s.
- FSM states: IDLE, START, DATA, PARITY (only with macro), STOP, BREAK.
- IDLE: on rx_s=0, go to START and clear the bit-period counter.
- START: after BAUD_DIV/2 cycles, sample rx_s.
  - If 1 (false start/glitch), return to IDLE with no error.
  - If 0, go to DATA with the counter restarted.
- DATA: every BAUD_DIV cycles, sample rx_s into a shift register, LSB first. After DATA_BITS samples, go to PARITY or STOP.
- PARITY: after BAUD_DIV cycles, sample the parity bit, then go to STOP.
- STOP: after BAUD_DIV cycles, sample rx_s.
  - If 1: complete the frame and return to IDLE on the next cycle. A new start edge is accepted immediately (back-to-back frames).
  - If 0: pulse frame_err, discard the word, go to BREAK.
- BREAK: wait for rx_s=1, then go to IDLE (a held-low line yields exactly one frame_err).
- Frame completion, on the cycle after the stop sample:
  - If rx_valid=0, or the handshake (rx_valid & rx_ready) occurs in the same cycle: load rx_data and set rx_valid=1.
  - Otherwise: keep the old word, drop the new one, pulse overrun.
- A parity-errored word is still delivered, with parity_err pulsed in the completion cycle.
- rx_valid clears on the cycle after rx_valid & rx_ready, unless a new word loads in that same cycle (then it stays 1).
- rx_ready is ignored while rx_valid=0. rx_data does not change while rx_valid=1 and the word is not accepted.
- Latency from the `rx` pin falling edge to rx_valid rising: 2 + BAUD_DIV/2 + (DATA_BITS+1)*BAUD_DIV + 1 cycles.
  - Defaults, no parity: 155 cycles.
  - With parity: add BAUD_DIV.
- Counters are sized $clog2(BAUD_DIV) and $clog2(DATA_BITS+1) and wrap only by explicit clear.

Optional Feature:
UART_PARITY_EN
- Defined: the frame carries one even-parity bit after the data bits, with the PARITY state inserted before STOP. parity_err pulses when the XOR of the data bits and the parity bit is 1.
- Undefined: no PARITY state, the frame is start + data + stop, and parity_err is constant 0.

Test Plan:
- Defaults, send 0xA5 (line 0,1,0,1,0,0,1,0,1,1), rx_ready=1 → rx_valid rises exactly 155 clks after the start edge with rx_data=0xA5; rx_valid is high 1 cycle; no error pulses.
- 3 back-to-back frames 0x00, 0xFF, 0x3C with rx_ready=0 → first word held at 0x00 with rx_valid=1; overrun pulses once per later frame (2 pulses total); raising rx_ready then yields 0x00 only.
- Stop bit driven 0 for frame 0x55, then line held low 40 bit periods → one frame_err pulse, rx_valid stays 0; the next valid frame 0x12 is received correctly.
- rx low glitch of 4 clks in IDLE → no frame, no error, FSM back in IDLE; a following frame 0x81 is received correctly.
- UART_PARITY_EN: send 0x07 with parity bit 1 → rx_data=0x07, parity_err=0. Send 0x07 with parity bit 0 → rx_data=0x07, parity_err pulses 1 cycle with rx_valid rising. Latency is 171 clks.
- rst_n pulsed low for 3 clks during data bit 4 of frame 0x99 → all outputs 0 immediately and rx_valid never rises for that frame; the next frame 0x42 is received correctly.
